// File: rtl/hash_digest_serializer.sv
// hash_digest_serializer: streams the meaningful bytes of a captured hash vector as 64-bit AXI-Stream beats.
// Ports: clk/rst (sync active-high); algo_mode/din/din_valid capture side with in_ready;
// m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast stream side; overrun/mode_err one-cycle pulses;
// digest_cnt counts completed digests.
module hash_digest_serializer #(
  parameter int DIN_W = 1344,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       algo_mode,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] m_tdata,
  output logic [7:0]       m_tkeep,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             overrun,
  output logic             mode_err,
  output logic [CNT_W-1:0] digest_cnt
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [DIN_W-1:0] buf_q, buf_d;
  logic [4:0] idx_q, idx_d, beats_q, beats_d, beats_dec;
  logic [7:0] keep_q, keep_d;
  logic in_ready_q, in_ready_d, overrun_q, overrun_d, mode_err_q, mode_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mode_rsvd, capture, hs, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      beats_q    <= '0;
      keep_q     <= '0;
      in_ready_q <= 1'b1;
      overrun_q  <= 1'b0;
      mode_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
      keep_q     <= keep_d;
      in_ready_q <= in_ready_d;
      overrun_q  <= overrun_d;
      mode_err_q <= mode_err_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    mode_rsvd = algo_mode[3] & (algo_mode[2:1] == 2'b11);
    capture   = (state_q == IDLE) & din_valid & !mode_rsvd;
    hs        = (state_q == SEND) & m_tready;
    last      = idx_q == beats_q - 5'd1;
    state_d   = state_q == IDLE ? (capture ? SEND : IDLE) : (hs && last ? IDLE : SEND);
  end
  always_comb begin
    beats_dec = !algo_mode[3]          ? (algo_mode[0] ? 5'd8 : 5'd4) :
                algo_mode[2:0] == 3'd0 ? 5'd21 :
                algo_mode[2:0] == 3'd1 ? 5'd17 :
                algo_mode[2:0] == 3'd2 ? 5'd4  :
                algo_mode[2:0] == 3'd3 ? 5'd8  :
                algo_mode[2:0] == 3'd4 ? 5'd4  :
                algo_mode[2:0] == 3'd5 ? 5'd6  : 5'd0;
    buf_d      = capture ? din : hs ? {buf_q[DIN_W-OUT_W-1:0], {OUT_W{1'b0}}} : buf_q;
    idx_d      = capture ? 5'd0 : hs ? idx_q + 5'd1 : idx_q;
    beats_d    = capture ? beats_dec : beats_q;
    // SHA3-224 ends halfway through its fourth beat
    keep_d     = capture ? (algo_mode == 4'b1100 ? 8'hF0 : 8'hFF) : keep_q;
    in_ready_d = state_d == IDLE;
    overrun_d  = din_valid & (state_q == SEND);
    mode_err_d = din_valid & (state_q == IDLE) & mode_rsvd;
    cnt_d      = cnt_q + CNT_W'(hs && last);
  end
  always_comb begin
    m_tvalid   = state_q == SEND;
    m_tlast    = m_tvalid & last;
    m_tkeep    = !m_tvalid ? 8'h00 : m_tlast ? keep_q : 8'hFF;
    // unkept bytes are forced to zero so trailing din bits never leak out
    for (int j = 0; j < 8; j++) m_tdata[8*j +: 8] = buf_q[DIN_W-OUT_W+8*j +: 8] & {8{m_tkeep[j]}};
    in_ready   = in_ready_q;
    overrun    = overrun_q;
    mode_err   = mode_err_q;
    digest_cnt = cnt_q;
  end
endmodule

// File: doc/hash_digest_serializer.md
Name: hash_digest_serializer

Overview:
- Downstream of the integrated SHA2/SHAKE hash top.
- Captures the 1344-bit shared hash output (dout/dout_valid) together with the algo_mode in force.
- Streams only the meaningful digest bytes as 64-bit AXI-Stream beats, MSB-first, with tkeep/tlast.
- Single-entry buffer; back-pressure is exposed through in_ready.

Parameters:
- DIN_W, 1344, width of captured hash vector (fixed by hash top).
- OUT_W, 64, output beat width in bits; only 64 is supported.
- CNT_W, 16, width of the completed-digest counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- algo_mode  in  4  {algo_type, mode[2:0]}; same encoding as hash top; sampled with din_valid.
- din  in  1344  hash vector; digest left-aligned at din[1343] (MSB-first).
- din_valid  in  1  single-cycle pulse; digest present on din.
- in_ready  out  1  high when IDLE; capture permitted.
- m_tdata  out  64  digest beat, first byte in [63:56].
- m_tkeep  out  8  byte enables, [7] = byte in [63:56].
- m_tvalid  out  1  beat valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  final beat of digest.
- overrun  out  1  one-cycle pulse: din_valid while in_ready=0 (digest dropped).
- mode_err  out  1  one-cycle pulse: capture with reserved SHAKE mode 110/111 (digest dropped).
- digest_cnt  out  CNT_W  completed digests, wraps 0xFFFF->0.

Behaviour:
- Reset (rst=1 at clk edge) values:
  - Outputs: in_ready=1, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, overrun=0, mode_err=0, digest_cnt=0.
  - State IDLE; buffer and beat counter cleared.
- Reset mid-stream aborts the digest: m_tvalid=0 the next cycle and no tlast is issued.
- FSM states: IDLE, SEND.
- IDLE & din_valid & valid mode:
  - Latch din into the 1344-bit shift buffer and latch beats/last-keep from algo_mode.
  - Go to SEND; m_tvalid=1 the cycle after din_valid (latency 1).
- Beat count, by algo_mode:
  - SHA2 mode[0]=0 (SHA-256): 4 beats. mode[0]=1 (SHA-512): 8 beats. SHA2 ignores mode[2:1].
  - SHAKE 000 (SHAKE128, 1344 b): 21. 001 (SHAKE256, 1088 b): 17.
  - SHAKE 010 (SHA3-256): 4. 011 (SHA3-512): 8. 100 (SHA3-224, 224 b): 4. 101 (SHA3-384): 6.
- tkeep: 8'hFF on every beat, except the SHA3-224 last beat, which is 8'hF0 with m_tdata[31:0]=0.
- IDLE & din_valid & SHAKE 110/111: mode_err pulse the next cycle; stay IDLE; no beats.
- SEND:
  - m_tdata = buffer[1343:1280].
  - On m_tvalid & m_tready: shift buffer left 64 (zero-fill) and increment the 5-bit beat index.
  - m_tlast=1 exactly when beat index = beats-1.
- AXI stability: while m_tvalid & !m_tready, m_tdata, m_tkeep and m_tlast hold unchanged.
- End of digest, on handshake with m_tlast:
  - Next cycle: state IDLE, m_tvalid=0, in_ready=1, digest_cnt+1.
  - No same-cycle reload: a din_valid during the last handshake cycle counts as overrun.
- din_valid in SEND: overrun pulse next cycle; buffer and stream unaffected.
- din_valid with m_tready held low: the beat is held indefinitely; there is no timeout.
- Rules: algo_mode changes after capture have no effect on the stream in progress. in_ready is a registered decode of state == IDLE.

Test Plan:
- SHA-256:
  - Stimulus: algo_mode=4'b0000, din[1343:1088]=256'h0123...EF (ramp), m_tready=1.
  - Response: 4 beats on consecutive cycles from cycle+1; beat0=din[1343:1280]; tlast on beat3; tkeep=FF on all beats; digest_cnt=1.
- SHA3-224:
  - Stimulus: algo_mode=4'b1100.
  - Response: 4 beats; beat3 tkeep=8'hF0, tdata[31:0]=0; tlast on beat3.
- SHAKE128 with back-pressure:
  - Stimulus: algo_mode=4'b1000; m_tready toggling 1,0,0,1.
  - Response: exactly 21 beats; data stable during stalls; tlast on beat 20; din bits reproduced in order.
- Overrun:
  - Stimulus: second din_valid during SHA-512 beat 3, then a third din_valid on the tlast handshake cycle.
  - Response: two overrun pulses; the original 8 beats are unchanged; digest_cnt=1.
- Reserved mode:
  - Stimulus: algo_mode=4'b1110 with din_valid.
  - Response: mode_err pulse; m_tvalid stays 0; in_ready stays 1; digest_cnt unchanged.
- Reset mid-stream:
  - Stimulus: rst=1 for 1 cycle at SHAKE256 beat 9.
  - Response: next cycle m_tvalid=0, in_ready=1, digest_cnt=0; a new SHA-512 capture afterwards yields 8 correct beats.
